// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit.
//   muldiv_op_e    : operation encodings (op_i field)
//   muldiv_state_e : sequencing FSM state encodings
// Helper functions classify an op code as divide and/or signed.
package ex_muldiv_unit_pkg;

   typedef enum logic [1:0] {
      MULDIV_OP_MULT  = 2'b00,
      MULDIV_OP_MULTU = 2'b01,
      MULDIV_OP_DIV   = 2'b10,
      MULDIV_OP_DIVU  = 2'b11
   } muldiv_op_e;

   typedef enum logic [1:0] {
      MULDIV_IDLE = 2'b00,
      MULDIV_MUL  = 2'b01,
      MULDIV_DIV  = 2'b10,
      MULDIV_DONE = 2'b11
   } muldiv_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_step.sv
// ex_div_step: one combinational step of restoring long division.
// Ports:
//   rem_i     partial remainder (DATA_W+1 bits)
//   divisor_i divisor magnitude
//   bit_i     next dividend bit, MSB first
//   rem_o     updated partial remainder
//   q_o       quotient bit produced by this step
module ex_div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W:0]   rem_i,
   input  logic [DATA_W-1:0] divisor_i,
   input  logic              bit_i,
   output logic [DATA_W:0]   rem_o,
   output logic              q_o
);

   logic [DATA_W+1:0] shifted;
   logic [DATA_W+1:0] trial;

   // One spare bit above the shifted remainder acts as the borrow of the trial subtract.
   always_comb begin
      shifted = {rem_i, bit_i};
      trial   = shifted - {2'b00, divisor_i};
      q_o     = ~trial[DATA_W+1];
      rem_o   = q_o ? trial[DATA_W:0] : shifted[DATA_W:0];
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU.
// Returns {hi,lo}: the product, or {remainder,quotient}. Requests a pipeline
// stall while busy and honours a flush (annul_i) while an operation is in flight.
// Ports:
//   clk, rst (async, active low)
//   start_i, op_i, opdata1_i, opdata2_i  operation request
//   annul_i                              abort in-flight operation
//   busy_o                               stall request (combinational)
//   ready_o                              one-cycle result-valid pulse
//   result_o                             {hi,lo}, held until next completion
//   div_zero_o                           qualifies ready_o: divisor was zero
// Build option MULDIV_FAST_MUL_EN: single-cycle combinational multiplier instead
// of the DATA_W-cycle shift-add datapath. Division is the same in both builds.
//
// state | meaning
// IDLE  | waiting for start_i; operands latched on the accepting edge
// MUL   | multiplying (shift-add iterations, or one cycle in the fast build)
// DIV   | restoring division, one quotient bit per cycle; exits at once on divide by zero
// DONE  | result_o valid, ready_o high for this single cycle
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [1:0]          op_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                annul_i,
   output logic                busy_o,
   output logic                ready_o,
   output logic [2*DATA_W-1:0] result_o,
   output logic                div_zero_o
);

   muldiv_state_e       state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic                go, last_iter, mul_done, load_res;
   logic                is_signed, a_neg, b_neg;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic                neg_res_q, neg_rem_q, b_zero_q;
   logic [DATA_W-1:0]   dividend_q, divisor_q, dq_q;
   logic [DATA_W:0]     rem_q, rem_nxt;
   logic                q_bit;
   logic [DATA_W-1:0]   quo, remv;
   logic [2*DATA_W-1:0] mul_mag, mul_res, div_res, res_nxt, result_q;
   logic                dz_q;

   assign go        = (state_q == MULDIV_IDLE) & start_i & ~annul_i;
   assign is_signed = op_is_signed(op_i);
   assign a_neg     = is_signed & opdata1_i[DATA_W-1];
   assign b_neg     = is_signed & opdata2_i[DATA_W-1];
   assign a_mag     = a_neg ? -opdata1_i : opdata1_i;
   assign b_mag     = b_neg ? -opdata2_i : opdata2_i;
   assign last_iter = (cnt_q == '0);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= MULDIV_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      ready_o = 1'b0;
      case (state_q)
         MULDIV_IDLE: begin
            if (go) begin
               busy_o  = 1'b1;
               state_d = op_is_div(op_i) ? MULDIV_DIV : MULDIV_MUL;
            end
         end
         MULDIV_MUL: begin
            busy_o = 1'b1;
            if (annul_i)       state_d = MULDIV_IDLE;
            else if (mul_done) state_d = MULDIV_DONE;
         end
         MULDIV_DIV: begin
            busy_o = 1'b1;
            if (annul_i)                    state_d = MULDIV_IDLE;
            else if (b_zero_q || last_iter) state_d = MULDIV_DONE;
         end
         MULDIV_DONE: begin
            ready_o = 1'b1;
            state_d = MULDIV_IDLE;
         end
         default: state_d = MULDIV_IDLE;
      endcase
   end

   // Iteration timer: loaded with DATA_W-1, last iteration at terminal count zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (go) begin
         cnt_q <= CNT_W'(DATA_W - 1);
      end else if ((state_q == MULDIV_MUL || state_q == MULDIV_DIV) && !last_iter) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // ---------------- operand latch and divider ----------------
   // dq_q starts as the dividend magnitude; dividend bits shift out of the top
   // while quotient bits shift in at the bottom.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         b_zero_q   <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         dq_q       <= '0;
         rem_q      <= '0;
      end else if (go) begin
         neg_res_q  <= a_neg ^ b_neg;
         neg_rem_q  <= a_neg;
         b_zero_q   <= (opdata2_i == '0);
         dividend_q <= opdata1_i;
         divisor_q  <= b_mag;
         dq_q       <= a_mag;
         rem_q      <= '0;
      end else if (state_q == MULDIV_DIV) begin
         rem_q <= rem_nxt;
         dq_q  <= {dq_q[DATA_W-2:0], q_bit};
      end
   end

   ex_div_step #(.DATA_W(DATA_W)) u_div_step (
      .rem_i     (rem_q),
      .divisor_i (divisor_q),
      .bit_i     (dq_q[DATA_W-1]),
      .rem_o     (rem_nxt),
      .q_o       (q_bit)
   );

   // ---------------- multiplier ----------------
`ifdef MULDIV_FAST_MUL_EN
   // The operand latch already holds both magnitudes (dq_q, divisor_q), and
   // neither shifts outside DIV, so they feed the multiplier directly.
   assign mul_done = 1'b1;
   assign mul_mag  = {{DATA_W{1'b0}}, dq_q} * {{DATA_W{1'b0}}, divisor_q};
`else
   logic [2*DATA_W-1:0] acc_q, mcand_q, acc_nxt;
   logic [DATA_W-1:0]   mplier_q;

   assign mul_done = last_iter;
   assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_mag  = acc_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (go) begin
         acc_q    <= '0;
         mcand_q  <= {{DATA_W{1'b0}}, a_mag};
         mplier_q <= b_mag;
      end else if (state_q == MULDIV_MUL) begin
         acc_q    <= acc_nxt;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end
`endif

   // ---------------- sign fix-up and result register ----------------
   // Values are taken from the final iteration's next-state so the result
   // register loads on the same edge that enters DONE.
   assign quo     = {dq_q[DATA_W-2:0], q_bit};
   assign remv    = rem_nxt[DATA_W-1:0];
   assign mul_res = neg_res_q ? -mul_mag : mul_mag;
   assign div_res = {(neg_rem_q ? -remv : remv), (neg_res_q ? -quo : quo)};

   always_comb begin
      res_nxt = mul_res;
      if (state_q == MULDIV_DIV) begin
         res_nxt = b_zero_q ? {dividend_q, {DATA_W{1'b1}}} : div_res;
      end
   end

   assign load_res = (state_d == MULDIV_DONE) && (state_q != MULDIV_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_q <= '0;
         dz_q     <= 1'b0;
      end else if (load_res) begin
         result_q <= res_nxt;
         dz_q     <= (state_q == MULDIV_DIV) && b_zero_q;
      end
   end

   assign result_o   = result_q;
   assign div_zero_o = ready_o & dz_q;

endmodule
